// File: rtl/btb_pkg.sv
// Shared types for the BTB update path: queue entry layout, record classes and FSM states.
package btb_pkg;

    // Queue entries carry PCs at this width; btb_updater's PC_BITS must not exceed it.
    localparam int BTB_PC_BITS = 32;

    typedef enum logic {
        UPD_WRITE,
        UPD_INVAL
    } upd_kind_e;

    typedef struct packed {
        upd_kind_e              kind;
        logic [BTB_PC_BITS-1:0] pc;
        logic [BTB_PC_BITS-1:0] target;
    } btb_upd_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWEEP
    } updater_state_e;

    typedef enum logic [1:0] {
        CLS_FILTER,
        CLS_WRITE,
        CLS_INVAL
    } res_class_e;

    // Mispredicted or missing taken branches need a write; stale hits on
    // not-taken branches need an invalidate; everything else is redundant.
    function automatic res_class_e classify(input logic taken,
                                            input logic hit,
                                            input logic tgt_match);
        if (taken && (!hit || !tgt_match)) begin
            return CLS_WRITE;
        end
        if (!taken && hit) begin
            return CLS_INVAL;
        end
        return CLS_FILTER;
    endfunction

endpackage

// File: rtl/btb_updater_if.sv
// Resolved-branch input, sweep control and BTB write/invalidate ports of the updater.
interface btb_updater_if #(
    parameter int PC_BITS = 32
);
    logic               res_valid;
    logic               res_ready;
    logic [PC_BITS-1:0] res_pc;
    logic [PC_BITS-1:0] res_target;
    logic               res_taken;
    logic               res_btb_hit;
    logic [PC_BITS-1:0] res_pred_target;

    logic               sweep_req;
    logic               sweep_busy;

    logic               wr_en;
    logic [PC_BITS-1:0] orig_pc;
    logic [PC_BITS-1:0] target_pc;

    logic               invalidate;
    logic [PC_BITS-1:0] pc_invalid;

    logic [15:0]        filt_count;

    modport master (
        output res_valid, res_pc, res_target, res_taken, res_btb_hit,
               res_pred_target, sweep_req,
        input  res_ready, sweep_busy, wr_en, orig_pc, target_pc,
               invalidate, pc_invalid, filt_count
    );

    modport slave (
        input  res_valid, res_pc, res_target, res_taken, res_btb_hit,
               res_pred_target, sweep_req,
        output res_ready, sweep_busy, wr_en, orig_pc, target_pc,
               invalidate, pc_invalid, filt_count
    );
endinterface

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO holding pending BTB updates; pointers carry one wrap bit for full/empty.
module btb_upd_fifo #(
    parameter type entry_t = logic,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/btb_updater.sv
// Filters resolved branches into BTB write/invalidate ops, queues them, and runs a full-table sweep on request.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accepting records, draining the queue one op per cycle
//   DRAIN | sweep requested; input blocked, remaining queued ops drained
//   SWEEP | issuing one invalidate per BTB line, index 0..SIZE-1
module btb_updater
    import btb_pkg::*;
#(
    parameter int PC_BITS = 32,
    parameter int SIZE    = 1024,
    parameter int DEPTH   = 4
) (
    input logic        clk,
    input logic        rst,
    btb_updater_if.slave bus
);
    localparam int SEL_BITS = $clog2(SIZE);
    localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(SIZE - 1);

    updater_state_e     state_q;
    updater_state_e     state_d;
    logic [SEL_BITS-1:0] idx_q;

    res_class_e         cls;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    btb_upd_t           push_entry;
    btb_upd_t           pop_entry;
    logic [PC_BITS-1:0] sweep_pc;

    logic               wr_en_q;
    logic               inv_q;
    logic [PC_BITS-1:0] orig_pc_q;
    logic [PC_BITS-1:0] target_pc_q;
    logic [PC_BITS-1:0] pc_invalid_q;
    logic [15:0]        filt_q;

    assign bus.res_ready  = (state_q == IDLE) && !fifo_full;
    assign bus.sweep_busy = (state_q != IDLE);

    assign accept = bus.res_valid && bus.res_ready;
    assign cls    = classify(bus.res_taken, bus.res_btb_hit,
                             bus.res_pred_target == bus.res_target);
    assign push   = accept && (cls != CLS_FILTER);
    assign pop    = !fifo_empty && ((state_q == IDLE) || (state_q == DRAIN));

    always_comb begin
        push_entry        = '0;
        push_entry.kind   = (cls == CLS_INVAL) ? UPD_INVAL : UPD_WRITE;
        push_entry.pc     = BTB_PC_BITS'(bus.res_pc);
        push_entry.target = (cls == CLS_INVAL) ? '0 : BTB_PC_BITS'(bus.res_target);
    end

    btb_upd_fifo #(
        .entry_t (btb_upd_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.sweep_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held at zero outside SWEEP so every sweep starts from line 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (state_q != SWEEP) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // Line index sits above bit 0, matching the BTB's 2-byte instruction granule.
    always_comb begin
        sweep_pc               = '0;
        sweep_pc[SEL_BITS:1]   = idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            inv_q        <= 1'b0;
            orig_pc_q    <= '0;
            target_pc_q  <= '0;
            pc_invalid_q <= '0;
            filt_q       <= '0;
        end else begin
            wr_en_q <= 1'b0;
            inv_q   <= 1'b0;
            if (pop) begin
                if (pop_entry.kind == UPD_WRITE) begin
                    wr_en_q     <= 1'b1;
                    orig_pc_q   <= PC_BITS'(pop_entry.pc);
                    target_pc_q <= PC_BITS'(pop_entry.target);
                end else begin
                    inv_q        <= 1'b1;
                    pc_invalid_q <= PC_BITS'(pop_entry.pc);
                end
            end else if (state_q == SWEEP) begin
                inv_q        <= 1'b1;
                pc_invalid_q <= sweep_pc;
            end
            if (accept && (cls == CLS_FILTER) && (filt_q != 16'hFFFF)) begin
                filt_q <= filt_q + 1'b1;
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.orig_pc    = orig_pc_q;
    assign bus.target_pc  = target_pc_q;
    assign bus.invalidate = inv_q;
    assign bus.pc_invalid = pc_invalid_q;
    assign bus.filt_count = filt_q;

endmodule

// File: tb/tb_btb_updater.sv
// Self-checking bench for btb_updater: directed scenarios plus randomized records against a queue model.
module tb_btb_updater;
    localparam int PCB = 32;
    localparam int SZ  = 8;
    localparam int DP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_updater_if #(.PC_BITS(PCB)) bus();

    btb_updater #(.PC_BITS(PCB), .SIZE(SZ), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Observed op stream: {is_inval, pc, target}
    logic [64:0] obs[$];
    int          both_err = 0;
    logic        mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.wr_en && bus.invalidate) both_err++;
            if (bus.wr_en)      obs.push_back({1'b0, bus.orig_pc, bus.target_pc});
            if (bus.invalidate) obs.push_back({1'b1, bus.pc_invalid, 32'h0});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.res_valid       = 1'b0;
        bus.res_pc          = '0;
        bus.res_target      = '0;
        bus.res_taken       = 1'b0;
        bus.res_btb_hit     = 1'b0;
        bus.res_pred_target = '0;
        bus.sweep_req       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_rec(input logic taken, input logic hit, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic [31:0] pred);
        bus.res_valid       = 1'b1;
        bus.res_taken       = taken;
        bus.res_btb_hit     = hit;
        bus.res_pc          = pc;
        bus.res_target      = tgt;
        bus.res_pred_target = pred;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %0b want 0", bus.wr_en); end
        checks++; if (bus.invalidate !== 1'b0) begin errors++; $display("FAIL rst_invalidate: got %0b want 0", bus.invalidate); end
        checks++; if (bus.orig_pc !== 32'h0) begin errors++; $display("FAIL rst_orig_pc: got %0h want 0", bus.orig_pc); end
        checks++; if (bus.target_pc !== 32'h0) begin errors++; $display("FAIL rst_target_pc: got %0h want 0", bus.target_pc); end
        checks++; if (bus.pc_invalid !== 32'h0) begin errors++; $display("FAIL rst_pc_invalid: got %0h want 0", bus.pc_invalid); end
        checks++; if (bus.filt_count !== 16'h0) begin errors++; $display("FAIL rst_filt_count: got %0h want 0", bus.filt_count); end
        checks++; if (bus.sweep_busy !== 1'b0) begin errors++; $display("FAIL rst_sweep_busy: got %0b want 0", bus.sweep_busy); end
        checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL rst_res_ready: got %0b want 1", bus.res_ready); end
    endtask

    task automatic test_write_basic();
        drive_rec(1'b1, 1'b0, 32'h100, 32'h200, 32'h0);
        checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0b want 1", bus.res_ready); end
        step();
        idle_inputs();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL wr_t1_wr_en: got %0b want 0", bus.wr_en); end
        step();
        checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL wr_t2_wr_en: got %0b want 1", bus.wr_en); end
        checks++; if (bus.orig_pc !== 32'h100) begin errors++; $display("FAIL wr_t2_orig_pc: got %0h want 100", bus.orig_pc); end
        checks++; if (bus.target_pc !== 32'h200) begin errors++; $display("FAIL wr_t2_target_pc: got %0h want 200", bus.target_pc); end
        checks++; if (bus.invalidate !== 1'b0) begin errors++; $display("FAIL wr_t2_invalidate: got %0b want 0", bus.invalidate); end
        step();
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL wr_t3_wr_en: got %0b want 0", bus.wr_en); end
        checks++; if (bus.orig_pc !== 32'h100) begin errors++; $display("FAIL wr_t3_hold_pc: got %0h want 100", bus.orig_pc); end
    endtask

    task automatic test_inval_filter();
        drive_rec(1'b0, 1'b1, 32'h104, 32'h999, 32'h500);
        step();
        idle_inputs();
        step();
        checks++; if (bus.invalidate !== 1'b1) begin errors++; $display("FAIL inv_invalidate: got %0b want 1", bus.invalidate); end
        checks++; if (bus.pc_invalid !== 32'h104) begin errors++; $display("FAIL inv_pc_invalid: got %0h want 104", bus.pc_invalid); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL inv_wr_en: got %0b want 0", bus.wr_en); end
        step();
        checks++; if (bus.invalidate !== 1'b0) begin errors++; $display("FAIL inv_one_cycle: got %0b want 0", bus.invalidate); end
        drive_rec(1'b1, 1'b1, 32'h108, 32'h300, 32'h300);
        step();
        idle_inputs();
        step();
        checks++; if (bus.wr_en !== 1'b0 || bus.invalidate !== 1'b0) begin errors++; $display("FAIL filt_no_output: got wr=%0b inv=%0b want 0 0", bus.wr_en, bus.invalidate); end
        checks++; if (bus.filt_count !== 16'd1) begin errors++; $display("FAIL filt_count: got %0d want 1", bus.filt_count); end
        checks++; if (bus.orig_pc !== 32'h100 || bus.pc_invalid !== 32'h104) begin errors++; $display("FAIL filt_hold: got orig=%0h pinv=%0h want 100 104", bus.orig_pc, bus.pc_invalid); end
    endtask

    task automatic test_back_to_back();
        int occ = 0;
        logic exp_ready;
        int   pop_n;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 5) drive_rec(1'b1, 1'b0, 32'h1000 + 32'(4*c), 32'h2000 + 32'(8*c), 32'h0);
            else idle_inputs();
            exp_ready = (occ < DP);
            checks++; if (bus.res_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready c%0d: got %0b want %0b", c, bus.res_ready, exp_ready); end
            if (c >= 2 && c <= 6) begin
                checks++;
                if (bus.wr_en !== 1'b1 || bus.orig_pc !== 32'h1000 + 32'(4*(c-2)) || bus.target_pc !== 32'h2000 + 32'(8*(c-2)))
                    begin errors++; $display("FAIL b2b_out c%0d: got wr=%0b pc=%0h tg=%0h want rec %0d", c, bus.wr_en, bus.orig_pc, bus.target_pc, c-2); end
            end else begin
                checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL b2b_idle c%0d: got wr=%0b want 0", c, bus.wr_en); end
            end
            pop_n = (occ > 0) ? 1 : 0;
            occ = occ - pop_n + ((bus.res_valid && exp_ready) ? 1 : 0);
            step();
        end
    endtask

    task automatic test_sweep();
        logic        inv_s [40];
        logic        busy_s[40];
        logic        ev_k [16];
        logic [31:0] ev_pc[16];
        logic [31:0] ev_tg[16];
        int          ev_c [16];
        int          ev_n = 0;
        int          rdy_viol = 0;
        logic        exp_k;
        logic [31:0] exp_pc, exp_tg;
        int          last;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            if (c == 0) drive_rec(1'b1, 1'b0, 32'h40, 32'h80, 32'h0);
            if (c == 1) begin drive_rec(1'b0, 1'b1, 32'h44, 32'h0, 32'h0); bus.sweep_req = 1'b1; end
            if (c >= 2 && c <= 4) bus.sweep_req = 1'b1;
            inv_s[c]  = bus.invalidate;
            busy_s[c] = bus.sweep_busy;
            if (bus.sweep_busy && bus.res_ready) rdy_viol++;
            if ((bus.wr_en || bus.invalidate) && ev_n < 16) begin
                ev_k[ev_n]  = bus.invalidate;
                ev_pc[ev_n] = bus.invalidate ? bus.pc_invalid : bus.orig_pc;
                ev_tg[ev_n] = bus.invalidate ? 32'h0 : bus.target_pc;
                ev_c[ev_n]  = c;
                ev_n++;
            end
            step();
        end
        idle_inputs();
        checks++; if (ev_n != 2 + SZ) begin errors++; $display("FAIL sweep_op_count: got %0d want %0d", ev_n, 2 + SZ); end
        for (int i = 0; i < 2 + SZ && i < ev_n; i++) begin
            exp_k  = (i != 0);
            exp_pc = (i == 0) ? 32'h40 : (i == 1) ? 32'h44 : 32'(2*(i-2));
            exp_tg = (i == 0) ? 32'h80 : 32'h0;
            checks++;
            if (ev_k[i] !== exp_k || ev_pc[i] !== exp_pc || ev_tg[i] !== exp_tg)
                begin errors++; $display("FAIL sweep_op%0d: got k=%0b pc=%0h tg=%0h want k=%0b pc=%0h tg=%0h", i, ev_k[i], ev_pc[i], ev_tg[i], exp_k, exp_pc, exp_tg); end
        end
        if (ev_n == 2 + SZ) begin
            last = ev_c[ev_n-1];
            checks++; if (last - ev_c[2] != SZ - 1) begin errors++; $display("FAIL sweep_consecutive: got span %0d want %0d", last - ev_c[2], SZ - 1); end
            checks++; if (last + 1 < 40 && (inv_s[last+1] !== 1'b0 || busy_s[last+1] !== 1'b0))
                begin errors++; $display("FAIL sweep_end: got inv=%0b busy=%0b want 0 0", inv_s[last+1], busy_s[last+1]); end
        end
        checks++; if (busy_s[2] !== 1'b1) begin errors++; $display("FAIL sweep_busy_start: got %0b want 1", busy_s[2]); end
        checks++; if (rdy_viol != 0) begin errors++; $display("FAIL sweep_ready_low: got %0d ready cycles want 0", rdy_viol); end
    endtask

    task automatic test_reset_mid_sweep();
        logic found = 1'b0;
        int   late_inv = 0;
        do_reset();
        drive_rec(1'b1, 1'b1, 32'h10, 32'h20, 32'h20);
        step();
        idle_inputs();
        bus.sweep_req = 1'b1;
        step();
        bus.sweep_req = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.invalidate && bus.pc_invalid == 32'h6) found = 1'b1;
            else step();
        end
        checks++; if (!found) begin errors++; $display("FAIL rstsw_timeout: got no index-3 invalidate want one within 40 cycles"); end
        rst = 1'b1;
        step();
        checks++; if (bus.invalidate !== 1'b0) begin errors++; $display("FAIL rstsw_invalidate: got %0b want 0", bus.invalidate); end
        checks++; if (bus.sweep_busy !== 1'b0) begin errors++; $display("FAIL rstsw_busy: got %0b want 0", bus.sweep_busy); end
        checks++; if (bus.filt_count !== 16'h0) begin errors++; $display("FAIL rstsw_filt: got %0d want 0", bus.filt_count); end
        checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL rstsw_ready: got %0b want 1", bus.res_ready); end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.invalidate) late_inv++;
            step();
        end
        checks++; if (late_inv != 0) begin errors++; $display("FAIL rstsw_no_more_inval: got %0d want 0", late_inv); end
    endtask

    task automatic test_random();
        logic [64:0] expq[$];
        int          filt_exp = 0;
        int          occ = 0;
        int          pop_n;
        logic        exp_ready, acc;
        logic        tk, ht;
        logic [31:0] pc, tg, pr;
        do_reset();
        obs.delete();
        both_err = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tk = 1'($urandom_range(0, 1));
            ht = 1'($urandom_range(0, 1));
            pc = $urandom & 32'hFFFF_FFFC;
            tg = $urandom;
            pr = ($urandom_range(0, 1) == 1) ? tg : $urandom;
            drive_rec(tk, ht, pc, tg, pr);
            bus.res_valid = ($urandom_range(0, 3) != 0);
            exp_ready = (occ < DP);
            checks++; if (bus.res_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, bus.res_ready, exp_ready); end
            acc = bus.res_valid && exp_ready;
            pop_n = (occ > 0) ? 1 : 0;
            occ = occ - pop_n;
            if (acc) begin
                if (tk && (!ht || pr != tg)) begin expq.push_back({1'b0, pc, tg}); occ++; end
                else if (!tk && ht) begin expq.push_back({1'b1, pc, 32'h0}); occ++; end
                else if (filt_exp < 65535) filt_exp++;
            end
            step();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();
        mon_en = 1'b0;
        checks++; if (obs.size() != expq.size()) begin errors++; $display("FAIL rnd_op_count: got %0d want %0d", obs.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            checks++; if (obs[i] !== expq[i]) begin errors++; $display("FAIL rnd_op%0d: got %0h want %0h", i, obs[i], expq[i]); end
        end
        checks++; if (bus.filt_count !== 16'(filt_exp)) begin errors++; $display("FAIL rnd_filt_count: got %0d want %0d", bus.filt_count, filt_exp); end
        checks++; if (both_err != 0) begin errors++; $display("FAIL rnd_exclusive: got %0d overlap cycles want 0", both_err); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_basic();
        test_inval_filter();
        test_back_to_back();
        test_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
